// File: rtl/cdb_pkg.sv
// Shared types for the common data bus arbiter: unit indices and the broadcast packet.
// The packet fields are sized by CDB_TAG_W / CDB_DATA_W, which match the arbiter's default parameters.
package cdb_pkg;

    localparam int NUM_UNITS  = 4;
    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MUL = 2'd1,
        UNIT_DIV = 2'd2,
        UNIT_LSU = 2'd3
    } unit_e;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        unit_e                 src;
    } cdb_pkt_t;

    // Successor in the round-robin order; the 2-bit add wraps LSU back to ALU.
    function automatic unit_e next_unit(input unit_e u);
        return unit_e'(u + 2'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way rotating-priority selector: the first requester found starting at i_ptr wins.
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter4
    import cdb_pkg::*;
(
    input  logic [NUM_UNITS-1:0] i_req,
    input  logic [1:0]           i_ptr,
    output logic [NUM_UNITS-1:0] o_gnt,
    output logic [1:0]           o_idx,
    output logic                 o_any
);

    logic [1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        // Scan from the lowest priority upward so the highest-priority hit is the last one written.
        for (int off = NUM_UNITS - 1; off >= 0; off--) begin
            w_cand = i_ptr + 2'(off);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
        o_gnt[o_idx] = o_any;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one of four result producers per cycle and broadcasts it one cycle later.
// Build option: define CDB_FIXED_PRIORITY_EN for fixed priority ALU > MUL > DIV > LSU (no rotating pointer).
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_UNITS-1:0]             req_valid_i,
    input  logic [NUM_UNITS-1:0][TAG_W-1:0]  req_tag_i,
    input  logic [NUM_UNITS-1:0][WIDTH-1:0]  req_data_i,
    output logic [NUM_UNITS-1:0]             req_ready_o,
    output logic                             cdb_valid_o,
    output logic [TAG_W-1:0]                 cdb_tag_o,
    output logic [WIDTH-1:0]                 cdb_data_o,
    output logic [1:0]                       cdb_src_o
);

    logic [NUM_UNITS-1:0] w_gnt;
    logic [1:0]           w_idx;
    logic                 w_any;
    logic [1:0]           w_ptr;
    logic                 w_xfer;
    cdb_pkt_t             r_pkt;

`ifdef CDB_FIXED_PRIORITY_EN
    assign w_ptr = 2'd0;
`else
    unit_e r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= UNIT_ALU;
        end else if (w_xfer) begin
            r_ptr <= next_unit(unit_e'(w_idx));
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_arbiter4 u_rr_arbiter4 (
        .i_req (req_valid_i),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Grants are masked by reset so nothing is accepted while the bus is being cleared.
    assign req_ready_o = rst ? '0 : w_gnt;
    assign w_xfer      = w_any & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt <= '0;
        end else begin
            r_pkt.valid <= w_xfer;
            if (w_xfer) begin
                r_pkt.tag  <= CDB_TAG_W'(req_tag_i[w_idx]);
                r_pkt.data <= CDB_DATA_W'(req_data_i[w_idx]);
                r_pkt.src  <= unit_e'(w_idx);
            end
        end
    end

    assign cdb_valid_o = r_pkt.valid;
    assign cdb_tag_o   = TAG_W'(r_pkt.tag);
    assign cdb_data_o  = WIDTH'(r_pkt.data);
    assign cdb_src_o   = r_pkt.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table, directed corner cases and a randomized run against a queue-level model.
// Honours CDB_FIXED_PRIORITY_EN the same way the design does.
module tb_cdb_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][5:0]  req_tag;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ready;
    logic             cdb_valid;
    logic [5:0]       cdb_tag;
    logic [31:0]      cdb_data;
    logic [1:0]       cdb_src;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        int         src;
    } vec_t;

    vec_t vecs[$];

    cdb_arbiter #(.WIDTH(32), .TAG_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_tag_i   (req_tag),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .cdb_valid_o (cdb_valid),
        .cdb_tag_o   (cdb_tag),
        .cdb_data_o  (cdb_data),
        .cdb_src_o   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_unit_payloads();
        for (int k = 0; k < 4; k++) begin
            req_tag[k]  = 6'(8'h10 + k);
            req_data[k] = 32'hA000_0000 + 32'(k);
        end
    endtask

    // Reference: rotating priority from pointer p, pending requests held until granted.
    logic [3:0]  m_pv;
    logic [5:0]  m_ptag [4];
    logic [31:0] m_pdata[4];
    int          m_p;
    logic        m_v;
    logic [5:0]  m_tag;
    logic [31:0] m_data;
    int          m_src;

    function automatic int model_pick(input logic [3:0] v, input int p);
        for (int off = 0; off < 4; off++) begin
            if (v[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    initial begin
        int g;
        int exp_src;

        rst       = 1'b1;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;

`ifdef CDB_FIXED_PRIORITY_EN
        vecs.push_back('{4'b0001, 4'b0001, 0});
        vecs.push_back('{4'b0000, 4'b0000, -1});
        vecs.push_back('{4'b1001, 4'b0001, 0});
        vecs.push_back('{4'b1010, 4'b0010, 1});
        vecs.push_back('{4'b1100, 4'b0100, 2});
        vecs.push_back('{4'b1000, 4'b1000, 3});
        vecs.push_back('{4'b1111, 4'b0001, 0});
        vecs.push_back('{4'b1110, 4'b0010, 1});
`else
        vecs.push_back('{4'b0001, 4'b0001, 0});
        vecs.push_back('{4'b0000, 4'b0000, -1});
        vecs.push_back('{4'b1001, 4'b1000, 3});
        vecs.push_back('{4'b0011, 4'b0001, 0});
        vecs.push_back('{4'b0110, 4'b0010, 1});
        vecs.push_back('{4'b1100, 4'b0100, 2});
        vecs.push_back('{4'b1001, 4'b1000, 3});
        vecs.push_back('{4'b1111, 4'b0001, 0});
        vecs.push_back('{4'b1110, 4'b0010, 1});
        vecs.push_back('{4'b1100, 4'b0100, 2});
        vecs.push_back('{4'b1000, 4'b1000, 3});
`endif

        // Reset with every unit requesting.
        req_valid = 4'b1111;
        set_unit_payloads();
        #1;
        chk("rst_ready", 64'(req_ready), 64'(4'b0000));
        chk("rst_cdb_valid", 64'(cdb_valid), 64'(1'b0));
        @(posedge clk);
        #1;
        chk("rst_ready_edge", 64'(req_ready), 64'(4'b0000));
        chk("rst_cdb_valid_edge", 64'(cdb_valid), 64'(1'b0));
        chk("rst_cdb_tag", 64'(cdb_tag), 64'(0));
        chk("rst_cdb_data", 64'(cdb_data), 64'(0));
        chk("rst_cdb_src", 64'(cdb_src), 64'(0));
        rst = 1'b0;
        #1;
        chk("first_grant", 64'(req_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        chk("first_bcast_valid", 64'(cdb_valid), 64'(1'b1));
        chk("first_bcast_src", 64'(cdb_src), 64'(0));

        // Vector table from a freshly reset pointer.
        do_reset();
        set_unit_payloads();
        foreach (vecs[i]) begin
            req_valid = vecs[i].valid;
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_cdb_valid", i), 64'(cdb_valid), 64'(vecs[i].src >= 0));
            if (vecs[i].src >= 0) begin
                chk($sformatf("vec%0d_src", i), 64'(cdb_src), 64'(vecs[i].src));
                chk($sformatf("vec%0d_tag", i), 64'(cdb_tag), 64'(8'h10 + vecs[i].src));
            end
        end
        req_valid = '0;

        // Single requester with hold of last broadcast values.
        do_reset();
        req_tag[2]  = 6'h15;
        req_data[2] = 32'hDEADBEEF;
        req_valid   = 4'b0100;
        #1;
        chk("single_ready", 64'(req_ready), 64'(4'b0100));
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("single_valid", 64'(cdb_valid), 64'(1'b1));
        chk("single_tag", 64'(cdb_tag), 64'(6'h15));
        chk("single_data", 64'(cdb_data), 64'(32'hDEADBEEF));
        chk("single_src", 64'(cdb_src), 64'(2));
        @(posedge clk);
        #1;
        chk("single_drop_valid", 64'(cdb_valid), 64'(1'b0));
        chk("single_hold_data", 64'(cdb_data), 64'(32'hDEADBEEF));
        chk("single_hold_src", 64'(cdb_src), 64'(2));

        // All four requesting continuously for eight cycles.
        do_reset();
        set_unit_payloads();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
`ifdef CDB_FIXED_PRIORITY_EN
            exp_src = 0;
`else
            exp_src = i % 4;
`endif
            #1;
            chk($sformatf("fair%0d_ready", i), 64'(req_ready), 64'(4'b0001 << exp_src));
            @(posedge clk);
            #1;
            chk($sformatf("fair%0d_valid", i), 64'(cdb_valid), 64'(1'b1));
            chk($sformatf("fair%0d_src", i), 64'(cdb_src), 64'(exp_src));
        end
        req_valid = '0;

        // Pointer wrap: grant LSU, then ALU and LSU together must pick ALU.
        do_reset();
        req_valid = 4'b1000;
        #1;
        chk("wrap_lsu_ready", 64'(req_ready), 64'(4'b1000));
        @(posedge clk);
        #1;
        req_valid = 4'b1001;
        #1;
        chk("wrap_alu_ready", 64'(req_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        chk("wrap_alu_src", 64'(cdb_src), 64'(0));
        req_valid = '0;

        // Reset arriving while unit 1 is being granted.
        do_reset();
        req_valid = 4'b0001;
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        #1;
        chk("midrst_ready_pre", 64'(req_ready), 64'(4'b0010));
        chk("midrst_valid_pre", 64'(cdb_valid), 64'(1'b1));
        #5;
        rst = 1'b1;
        #1;
        chk("midrst_ready_in_rst", 64'(req_ready), 64'(4'b0000));
        chk("midrst_valid_in_rst", 64'(cdb_valid), 64'(1'b0));
        @(posedge clk);
        #1;
        chk("midrst_valid_edge", 64'(cdb_valid), 64'(1'b0));
        req_valid = '0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid_after", 64'(cdb_valid), 64'(1'b0));
        chk("midrst_src_cleared", 64'(cdb_src), 64'(0));
        req_valid = 4'b1111;
        #1;
        chk("midrst_ptr_zero", 64'(req_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        req_valid = '0;

        // Randomized traffic against the model.
        do_reset();
        m_pv = '0;
        m_p  = 0;
        m_v  = 1'b0;
        m_tag = '0;
        m_data = '0;
        m_src = 0;
        for (int k = 0; k < 4; k++) begin
            m_ptag[k]  = '0;
            m_pdata[k] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_pv[k] && ($urandom_range(0, 2) == 0)) begin
                    m_pv[k]    = 1'b1;
                    m_ptag[k]  = 6'($urandom);
                    m_pdata[k] = $urandom;
                end
                req_valid[k] = m_pv[k];
                req_tag[k]   = m_ptag[k];
                req_data[k]  = m_pdata[k];
            end
            #1;
            g = model_pick(m_pv, m_p);
            chk("rand_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
            if (g >= 0) begin
                m_v    = 1'b1;
                m_tag  = m_ptag[g];
                m_data = m_pdata[g];
                m_src  = g;
                m_pv[g] = 1'b0;
`ifndef CDB_FIXED_PRIORITY_EN
                m_p = (g + 1) % 4;
`endif
            end else begin
                m_v = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rand_cdb_valid", 64'(cdb_valid), 64'(m_v));
            chk("rand_cdb_tag", 64'(cdb_tag), 64'(m_tag));
            chk("rand_cdb_data", 64'(cdb_data), 64'(m_data));
            chk("rand_cdb_src", 64'(cdb_src), 64'(m_src));
        end
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning result data width.
REQ-002 SHALL have parameter TAG_W, default 6, meaning reservation-station/ROB tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  4  per-unit result valid; unit 0=ALU, 1=MUL, 2=DIV, 3=LSU.
REQ-006 SHALL have port req_tag_i  input  4 x TAG_W  per-unit destination tag.
REQ-007 SHALL have port req_data_i  input  4 x WIDTH  per-unit result value.
REQ-008 SHALL have port req_ready_o  output  4  one-hot grant; unit k's result is accepted this cycle.
REQ-009 SHALL have port cdb_valid_o  output  1  broadcast valid.
REQ-010 SHALL have port cdb_tag_o  output  TAG_W  broadcast tag.
REQ-011 SHALL have port cdb_data_o  output  WIDTH  broadcast value.
REQ-012 SHALL have port cdb_src_o  output  2  index of the unit that produced the broadcast.

Function
REQ-013 SHALL grant at most one requester per cycle; req_ready_o is combinational from req_valid_i and priority pointer, zero when no valid.
REQ-014 SHALL treat a transfer as occurring when req_valid_i[k] and req_ready_o[k] are both high on a rising edge.
REQ-015 SHALL require requesters to hold valid, tag and data stable until accepted; arbiter need not tolerate withdrawal.
REQ-016 SHALL register the accepted tag/data/source into cdb_*_o, valid on the cycle after acceptance (latency 1).
REQ-017 SHALL drive cdb_valid_o low the cycle after any cycle with no transfer; cdb_tag_o/cdb_data_o/cdb_src_o hold last values.
REQ-018 SHALL not support CDB back-pressure; every broadcast lasts exactly one cycle.
REQ-019 SHALL use round-robin: pointer p (2 bits) gives priority p, p+1, p+2, p+3 mod 4.
REQ-020 SHALL update p to (granted index + 1) mod 4 after each transfer; p unchanged with no transfer.
REQ-021 SHALL wrap pointer 3 -> 0 without bubble.
REQ-022 SHALL with all four valid continuously grant each unit exactly once in any 4 consecutive cycles.
REQ-023 SHALL sustain one transfer per cycle with no idle cycle between back-to-back grants.

Reset
REQ-024 SHALL on rst asserted immediately clear cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_src_o and p to 0.
REQ-025 SHALL force req_ready_o to 0 while rst is high, regardless of req_valid_i.
REQ-026 SHALL drop any transfer in flight when rst asserts mid-operation; no broadcast after release until new acceptance.
REQ-027 SHALL begin arbitration on the first rising edge with rst low, priority starting at unit 0.

Configuration
REQ-028 SHALL, when macro CDB_FIXED_PRIORITY_EN is defined, use fixed priority 0>1>2>3 and omit pointer p.
REQ-029 SHALL, without CDB_FIXED_PRIORITY_EN, implement round-robin per REQ-019..REQ-022.

Structure
REQ-030 SHALL take NUM_UNITS=4, unit index enum (ALU, MUL, DIV, LSU) and cdb packet struct (valid, tag, data, src) from shared package cdb_pkg.
REQ-031 SHALL instantiate one sub-module rr_arbiter4 (request vector, pointer -> one-hot grant, grant index); output register and pointer live in cdb_arbiter.

Verification
REQ-032 SHALL test reset: rst=1 with all valid -> req_ready_o=0000, cdb_valid_o=0; after release first grant 0001.
REQ-033 SHALL test single requester: only unit 2 valid, tag 0x15, data 0xDEADBEEF -> ready=0100 same cycle; next cycle cdb_valid=1, tag 0x15, data 0xDEADBEEF, src=2.
REQ-034 SHALL test fairness: all four valid 8 cycles -> grant order 0,1,2,3,0,1,2,3, cdb_valid high 8 consecutive cycles.
REQ-035 SHALL test pointer wrap: grant unit 3, then units 0 and 3 valid -> unit 0 granted next.
REQ-036 SHALL test mid-operation reset: accept unit 1, assert rst before next edge -> cdb_valid_o stays 0, p=0.
REQ-037 SHALL test CDB_FIXED_PRIORITY_EN build: all valid 4 cycles -> unit 0 granted every cycle.
